ks_add_seq: RTL
===============

// Module: ks_add_seq
// PURPOSE
//  Sequences one shared 16-bit Kogge-Stone adder datapath over multi-word operands.
//  Accepts a wide add/sub request, feeds the adder one 16-bit slice per cycle LSW-first.
//  Chains carry through a register and assembles the wide result.
//  Sits between the ALU issue logic and the KS prefix-tree adder instantiated by the parent.
// PARAMETERS
//  WORDS  4  number of 16-bit slices per operand; operand width W = 16*WORDS; legal 1..16
// PORTS
//  i_clk        in   1        clock, rising edge
//  i_rst        in   1        reset, asynchronous, active-high
//  i_valid      in   1        request valid
//  o_ready      out  1        request accept; high only in IDLE
//  i_sub        in   1        1 = a - b, 0 = a + b
//  i_a          in   W        operand a
//  i_b          in   W        operand b
//  o_valid      out  1        result valid
//  i_ready      in   1        result accept
//  o_sum        out  W        result
//  o_cout       out  1        carry out of MSB (sub: 1 = no borrow)
//  o_add_a      out  16       slice to adder operand a
//  o_add_b      out  16       slice to adder operand b (pre-inverted when sub)
//  o_add_cin    out  1        adder carry in (i_c0 of the tree)
//  i_add_sum    in   16       adder sum, combinational from o_add_*
//  i_add_cout   in   1        adder carry out
// BEHAVIOUR
//  - Reset: state IDLE; o_ready=1; o_valid=0; o_sum=0; o_cout=0; slice count=0; carry reg=0.
//  - States: IDLE -> RUN on i_valid&o_ready; RUN -> DONE when count==WORDS-1;
//    DONE -> IDLE on i_valid... no: DONE -> IDLE on o_valid&i_ready.
//  - Accept edge E0: latch a, b (b inverted if i_sub), carry reg = i_sub, count = 0.
//  - RUN, cycle k (k=0..WORDS-1): o_add_a/o_add_b = slice k, o_add_cin = carry reg;
//    at edge: o_sum[16k+15:16k] <= i_add_sum, carry reg <= i_add_cout, count++.
//  - o_valid rises at edge E0+WORDS; latency WORDS cycles; o_cout = final carry reg.
//  - Outside RUN: o_add_a/o_add_b/o_add_cin driven 0 (adder quiet).
//  - DONE: o_sum/o_cout/o_valid held stable until i_ready; o_ready=0.
//  - i_valid ignored while o_ready=0; no queueing. One idle cycle between back-to-back ops
//    (DONE -> IDLE, accept on next edge); throughput 1 op per WORDS+2 cycles minimum.
//  - Carry chain: slice k carry-in = slice k-1 carry-out; wrap-around beyond W discarded
//    except as o_cout.
//  - o_sum slices not yet computed hold previous-op values during RUN; consumers use o_valid.
//  - WORDS=1: RUN lasts exactly one cycle.
//  - Reset mid-operation (any state): immediate return to reset values; op discarded.
// CONFIGURATION
//  KS_SEQ_OVF_EN defined: extra output o_ovf (1 bit), signed overflow of the W-bit op =
//    carry into MSB XOR carry out of MSB; captured with final slice; reset 0;
//    held with o_sum in DONE.
//  KS_SEQ_OVF_EN undefined: o_ovf port and logic absent; all else identical.
// TESTING (WORDS=4 unless noted)
//  1. a=0x0000_0000_0000_FFFF, b=1, add -> o_sum=0x0000_0000_0001_0000, o_cout=0;
//     o_valid exactly 4 cycles after accept.
//  2. a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> o_sum=0, o_cout=1; carry ripples all 4 slices.
//  3. a=0, b=1, sub -> o_sum=0xFFFF_FFFF_FFFF_FFFF, o_cout=0; with KS_SEQ_OVF_EN:
//     a=0x8000_0000_0000_0000, b=1, sub -> o_sum=0x7FFF_FFFF_FFFF_FFFF, o_ovf=1.
//  4. Hold i_ready=0 for 3 cycles in DONE with i_valid=1 and changing a/b
//     -> o_sum, o_cout and o_valid stable; o_ready=0; new request accepted only after release.
//  5. Assert i_rst during RUN slice 2 -> o_valid=0, o_ready=1 async.
//     Next op 5+7 -> o_sum=12, o_cout=0.
//  6. WORDS=1: 0xFFFF+0x0001 -> o_sum=0, o_cout=1, o_valid 1 cycle after accept.

Source files
------------

// File: rtl/ks_add_seq_if.sv
// Request/result handshake bundle for ks_add_seq.
// master = issue side (drives requests, accepts results), slave = sequencer.
// Optional o_ovf member is present only when KS_SEQ_OVF_EN is defined.
interface ks_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         i_valid;
    logic         o_ready;
    logic         i_sub;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
`ifdef KS_SEQ_OVF_EN
    logic         o_ovf;
`endif

    modport master (
`ifdef KS_SEQ_OVF_EN
        input  o_ovf,
`endif
        output i_valid, i_sub, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_sum, o_cout
    );

    modport slave (
`ifdef KS_SEQ_OVF_EN
        output o_ovf,
`endif
        input  i_valid, i_sub, i_a, i_b, i_ready,
        output o_ready, o_valid, o_sum, o_cout
    );
endinterface

// File: rtl/ks_add_seq.sv
// ks_add_seq: drives a shared external 16-bit adder one slice per cycle,
// LSW first, chaining the carry through a register and assembling a
// WORDS*16-bit add/sub result. Subtraction feeds ~b with carry-in 1.
// Optional feature: define KS_SEQ_OVF_EN to add the signed-overflow output
// (bus.o_ovf), captured alongside the final slice.
module ks_add_seq #(
    parameter int WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ks_add_seq_if.slave bus,
    output logic [15:0] o_add_a,
    output logic [15:0] o_add_b,
    output logic        o_add_cin,
    input  logic [15:0] i_add_sum,
    input  logic        i_add_cout
);
    localparam int W  = 16 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q;        // slices not yet presented to the adder
    logic [W-1:0]  b_q;
    logic          carry_q;    // carry out of the most recent slice
    logic          ready_q;
    logic          valid_q;
    logic [15:0]   add_a_q;
    logic [15:0]   add_b_q;
    logic          add_cin_q;
    logic [W-1:0]  b_eff;
    logic          last_slice;
    logic [W-1:0]  sum_w;

    assign b_eff      = bus.i_sub ? ~bus.i_b : bus.i_b;
    assign last_slice = (cnt_q == CW'(WORDS - 1));

`ifdef KS_SEQ_OVF_EN
    logic ovf_q;
    logic ovf_d;
    // Carry into the MSB is recovered from the MSB sum bit of the final slice.
    assign ovf_d   = (o_add_a[15] ^ o_add_b[15] ^ i_add_sum[15]) ^ i_add_cout;
    assign bus.o_ovf = ovf_q;
`endif

    // Control FSM plus the registered adder-side drive; adder inputs are
    // loaded one edge ahead so they are valid throughout each RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
`ifdef KS_SEQ_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        add_a_q   <= bus.i_a[15:0];
                        add_b_q   <= b_eff[15:0];
                        add_cin_q <= bus.i_sub;
                        a_q       <= bus.i_a >> 16;
                        b_q       <= b_eff >> 16;
                        carry_q   <= bus.i_sub;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= i_add_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_slice) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        add_a_q   <= '0;
                        add_b_q   <= '0;
                        add_cin_q <= 1'b0;
`ifdef KS_SEQ_OVF_EN
                        ovf_q     <= ovf_d;
`endif
                    end else begin
                        add_a_q   <= a_q[15:0];
                        add_b_q   <= b_q[15:0];
                        add_cin_q <= i_add_cout;
                        a_q       <= a_q >> 16;
                        b_q       <= b_q >> 16;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // One result register per slice, written only while that slice is on the adder.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
        logic [15:0] slice_q;

        // Capture adder sum for slice gi.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                slice_q <= '0;
            end else if (state_q == RUN && cnt_q == CW'(gi)) begin
                slice_q <= i_add_sum;
            end
        end

        assign sum_w[16*gi +: 16] = slice_q;
    end

    assign bus.o_sum   = sum_w;
    assign bus.o_cout  = carry_q;
    assign bus.o_valid = valid_q;
    assign bus.o_ready = ready_q;
    assign o_add_a     = add_a_q;
    assign o_add_b     = add_b_q;
    assign o_add_cin   = add_cin_q;
endmodule
